// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED pattern scheduler: FSM states,
// display modes, per-mode pattern lengths and the step-advance helper.
`timescale 1ns/1ps
package led_sched_pkg;

    localparam int LED_W  = 4;
    localparam int MODE_W = 3;
    localparam int STEP_W = 4;
    localparam int LEN_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [MODE_W-1:0] MODE_OFF    = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ON     = 3'd1;
    localparam logic [MODE_W-1:0] MODE_WALK_L = 3'd2;
    localparam logic [MODE_W-1:0] MODE_WALK_R = 3'd3;
    localparam logic [MODE_W-1:0] MODE_COUNT  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_BLINK  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_BOUNCE = 3'd6;
    localparam logic [MODE_W-1:0] MODE_FILL   = 3'd7;

    // Element [m] is the number of steps in mode m (mode 7 is the leftmost).
    localparam logic [7:0][LEN_W-1:0] MODE_LEN = {
        5'd5, 5'd6, 5'd2, 5'd16, 5'd4, 5'd4, 5'd1, 5'd1
    };

    function automatic logic [STEP_W-1:0] next_step(
        input logic [MODE_W-1:0] m,
        input logic [STEP_W-1:0] s
    );
        logic [LEN_W-1:0] last;
        last = MODE_LEN[m] - 5'd1;
        if ({1'b0, s} >= last) begin
            next_step = 4'd0;
        end else begin
            next_step = s + 4'd1;
        end
    endfunction

endpackage

// File: rtl/led_pattern_rom.sv
// Combinational pattern table: (mode, step) -> 4-bit LED pattern.
`timescale 1ns/1ps
module led_pattern_rom
    import led_sched_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    input  logic [STEP_W-1:0] step,
    output logic [LED_W-1:0]  pattern
);

    // Pattern lookup; out-of-range steps fall back to dark.
    always_comb begin
        pattern = 4'b0000;
        case (mode)
            MODE_OFF: pattern = 4'b0000;
            MODE_ON:  pattern = 4'b1111;
            MODE_WALK_L: begin
                case (step)
                    4'd0:    pattern = 4'b0001;
                    4'd1:    pattern = 4'b0010;
                    4'd2:    pattern = 4'b0100;
                    4'd3:    pattern = 4'b1000;
                    default: pattern = 4'b0000;
                endcase
            end
            MODE_WALK_R: begin
                case (step)
                    4'd0:    pattern = 4'b1000;
                    4'd1:    pattern = 4'b0100;
                    4'd2:    pattern = 4'b0010;
                    4'd3:    pattern = 4'b0001;
                    default: pattern = 4'b0000;
                endcase
            end
            MODE_COUNT: pattern = step;
            MODE_BLINK: begin
                if (step[0]) begin
                    pattern = 4'b1111;
                end else begin
                    pattern = 4'b0000;
                end
            end
            MODE_BOUNCE: begin
                case (step)
                    4'd0:    pattern = 4'b0001;
                    4'd1:    pattern = 4'b0010;
                    4'd2:    pattern = 4'b0100;
                    4'd3:    pattern = 4'b1000;
                    4'd4:    pattern = 4'b0100;
                    4'd5:    pattern = 4'b0010;
                    default: pattern = 4'b0000;
                endcase
            end
            MODE_FILL: begin
                case (step)
                    4'd0:    pattern = 4'b0000;
                    4'd1:    pattern = 4'b0001;
                    4'd2:    pattern = 4'b0011;
                    4'd3:    pattern = 4'b0111;
                    4'd4:    pattern = 4'b1111;
                    default: pattern = 4'b0000;
                endcase
            end
            default: pattern = 4'b0000;
        endcase
    end

endmodule

// File: rtl/led_pattern_sched.sv
// Key-driven LED sequencer (IDLE/RUN/PAUSE) with prescaled pattern stepping.
// Optional LED_SCHED_AUTO_EN adds automatic mode advance after AUTO_TICKS idle ticks.
`timescale 1ns/1ps
module led_pattern_sched
    import led_sched_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int AUTO_TICKS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_next,
    input  logic              key_prev,
    input  logic              key_pause,
    output logic [MODE_W-1:0] mode,
    output logic [LED_W-1:0]  led_out,
    output logic              running
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_PAUSE = PAUSE;

    localparam int                 PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(0);

    logic [1:0]         state_r,   state_nx_s;
    logic [MODE_W-1:0]  mode_r,    mode_nx_s;
    logic [STEP_W-1:0]  step_r,    step_nx_s;
    logic [PRESC_W-1:0] presc_r,   presc_nx_s;
    logic [LED_W-1:0]   led_r;
    logic [LED_W-1:0]   pat_s;
    logic               running_r;
    logic               tick_s;
    logic               any_key_s;
    logic               auto_fire_s;

    assign tick_s    = (presc_r == PRESC_LAST);
    assign any_key_s = key_next | key_prev | key_pause;

`ifdef LED_SCHED_AUTO_EN
    localparam int                IDLE_W    = $clog2(AUTO_TICKS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(AUTO_TICKS - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);

    logic [IDLE_W-1:0] idle_r, idle_nx_s;

    // A key edge always wins over the auto advance, so only keyless RUN ticks fire.
    assign auto_fire_s = (state_r == ST_RUN) && tick_s && !any_key_s && (idle_r == IDLE_LAST);

    // Idle counter next value: cleared by keys, counts RUN ticks only.
    always_comb begin
        idle_nx_s = idle_r;
        if (any_key_s) begin
            idle_nx_s = IDLE_ZERO;
        end else if ((state_r == ST_RUN) && tick_s) begin
            if (auto_fire_s) begin
                idle_nx_s = IDLE_ZERO;
            end else begin
                idle_nx_s = idle_r + IDLE_ONE;
            end
        end else begin
            idle_nx_s = idle_r;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_r <= IDLE_ZERO;
        end else begin
            idle_r <= idle_nx_s;
        end
    end
`else
    logic unused_auto_s;
    assign unused_auto_s = (AUTO_TICKS > 32'sd0);
    assign auto_fire_s   = 1'b0;
`endif

    // Next-state logic: pause beats next beats prev; a mode change restarts the step.
    always_comb begin
        state_nx_s = state_r;
        mode_nx_s  = mode_r;
        step_nx_s  = step_r;
        presc_nx_s = presc_r;
        case (state_r)
            ST_IDLE: begin
                if (any_key_s) begin
                    state_nx_s = ST_RUN;
                    mode_nx_s  = MODE_OFF;
                    step_nx_s  = 4'd0;
                    presc_nx_s = PRESC_ZERO;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (key_pause) begin
                    state_nx_s = ST_PAUSE;
                end else if (key_next || auto_fire_s) begin
                    mode_nx_s  = mode_r + 3'd1;
                    step_nx_s  = 4'd0;
                    presc_nx_s = PRESC_ZERO;
                end else if (key_prev) begin
                    mode_nx_s  = mode_r - 3'd1;
                    step_nx_s  = 4'd0;
                    presc_nx_s = PRESC_ZERO;
                end else if (tick_s) begin
                    step_nx_s  = next_step(mode_r, step_r);
                    presc_nx_s = PRESC_ZERO;
                end else begin
                    presc_nx_s = presc_r + PRESC_ONE;
                end
            end
            ST_PAUSE: begin
                // The resume edge already counts as a RUN cycle of the frozen step.
                if (key_pause) begin
                    state_nx_s = ST_RUN;
                    if (tick_s) begin
                        step_nx_s  = next_step(mode_r, step_r);
                        presc_nx_s = PRESC_ZERO;
                    end else begin
                        presc_nx_s = presc_r + PRESC_ONE;
                    end
                end else if (key_next) begin
                    mode_nx_s  = mode_r + 3'd1;
                    step_nx_s  = 4'd0;
                    presc_nx_s = PRESC_ZERO;
                end else if (key_prev) begin
                    mode_nx_s  = mode_r - 3'd1;
                    step_nx_s  = 4'd0;
                    presc_nx_s = PRESC_ZERO;
                end else begin
                    state_nx_s = ST_PAUSE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                mode_nx_s  = MODE_OFF;
                step_nx_s  = 4'd0;
                presc_nx_s = PRESC_ZERO;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            mode_r    <= MODE_OFF;
            step_r    <= 4'd0;
            presc_r   <= PRESC_ZERO;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            mode_r    <= mode_nx_s;
            step_r    <= step_nx_s;
            presc_r   <= presc_nx_s;
            running_r <= (state_nx_s == ST_RUN);
        end
    end

    led_pattern_rom u_rom (
        .mode    (mode_r),
        .step    (step_r),
        .pattern (pat_s)
    );

    // Output pattern register, one cycle behind mode/step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r <= 4'b0000;
        end else if (state_r == ST_IDLE) begin
            led_r <= 4'b0000;
        end else begin
            led_r <= pat_s;
        end
    end

    assign mode    = mode_r;
    assign led_out = led_r;
    assign running = running_r;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Self-checking bench for led_pattern_sched (TICK_DIV=4, AUTO_TICKS=3);
// a cycle model feeds a scoreboard, plus targeted timing checks per scenario.
`timescale 1ns/1ps
module tb_led_pattern_sched;

    localparam int TICK_DIV   = 4;
    localparam int AUTO_TICKS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       kn  = 1'b0;
    logic       kp  = 1'b0;
    logic       kpa = 1'b0;
    logic [2:0] mode;
    logic [3:0] led_out;
    logic       running;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0] mode;
        logic [3:0] led;
        logic       run;
    } exp_t;

    exp_t sb_q[$];

    int         m_st, m_mode, m_step, m_presc, m_idle;
    logic [3:0] m_led;
    int         len_tab[8] = '{1, 1, 4, 4, 16, 2, 6, 5};

    always #5 clk = ~clk;

    led_pattern_sched #(.TICK_DIV(TICK_DIV), .AUTO_TICKS(AUTO_TICKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_next  (kn),
        .key_prev  (kp),
        .key_pause (kpa),
        .mode      (mode),
        .led_out   (led_out),
        .running   (running)
    );

    function automatic logic [3:0] ref_pat(input int md, input int st);
        logic [3:0] one;
        logic [3:0] top;
        one = 4'b0001;
        top = 4'b1000;
        case (md)
            0:       return 4'b0000;
            1:       return 4'b1111;
            2:       return one << st;
            3:       return top >> st;
            4:       return 4'(st);
            5:       return (st % 2 == 1) ? 4'b1111 : 4'b0000;
            6:       return (st < 4) ? (one << st) : (one << (6 - st));
            7:       return 4'((1 << st) - 1);
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_mode = 0; m_step = 0; m_presc = 0; m_idle = 0; m_led = 4'b0000;
    endtask

    task automatic model_count(input bit allow_auto);
        if (m_presc == TICK_DIV - 1) begin
            m_presc = 0;
`ifdef LED_SCHED_AUTO_EN
            m_idle = m_idle + 1;
            if (allow_auto && m_idle == AUTO_TICKS) begin
                m_mode = (m_mode + 1) % 8;
                m_step = 0;
                m_idle = 0;
            end else begin
                m_step = (m_step + 1) % len_tab[m_mode];
            end
`else
            m_step = (m_step + 1) % len_tab[m_mode];
`endif
        end else begin
            m_presc = m_presc + 1;
        end
    endtask

    task automatic model_edge(input bit n, input bit p, input bit pa);
        m_led = (m_st == 0) ? 4'b0000 : ref_pat(m_mode, m_step);
        if (m_st == 0) begin
            if (n | p | pa) begin
                m_st = 1; m_mode = 0; m_step = 0; m_presc = 0;
            end
        end else if (pa) begin
            if (m_st == 1) m_st = 2;
            else begin
                m_st = 1;
                model_count(1'b0);
            end
        end else if (n | p) begin
            m_mode = n ? (m_mode + 1) % 8 : (m_mode + 7) % 8;
            m_step = 0;
            m_presc = 0;
        end else if (m_st == 1) begin
            model_count(1'b1);
        end
        if (n | p | pa) m_idle = 0;
    endtask

    // One clock: drive keys, predict, then compare after the edge.
    task automatic cycle(input bit n, input bit p, input bit pa);
        exp_t e;
        kn = n; kp = p; kpa = pa;
        model_edge(n, p, pa);
        e.mode = 3'(m_mode);
        e.led  = m_led;
        e.run  = (m_st == 1);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        kn = 1'b0; kp = 1'b0; kpa = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if ({mode, led_out, running} !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t: got mode=%0d led=%b run=%b, want mode=%0d led=%b run=%b",
                     $time, mode, led_out, running, e.mode, e.led, e.run);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({mode, led_out, running} !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: got mode=%0d led=%b run=%b, want 0/0000/0", mode, led_out, running);
        end
        #7 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_next_blink();
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (running !== 1'b1 || mode !== 3'd0) begin
            errors++;
            $display("FAIL idle_to_run: got run=%b mode=%0d, want 1/0", running, mode);
        end
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (mode !== 3'd5) begin
            errors++;
            $display("FAIL five_next: got mode=%0d, want 5", mode);
        end
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] want;
            cycle(1'b0, 1'b0, 1'b0);
            want = (((k - 1) / 4) % 2 == 1) ? 4'b1111 : 4'b0000;
            checks++;
            if (led_out !== want) begin
                errors++;
                $display("FAIL blink_k%0d: got led=%b, want %b", k, led_out, want);
            end
        end
    endtask

    task automatic test_fill();
        logic [3:0] fill_exp[5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
`ifdef LED_SCHED_AUTO_EN
        int fill_n = 11;
`else
        int fill_n = 21;
`endif
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (mode !== 3'd7) begin
            errors++;
            $display("FAIL prev_wrap: got mode=%0d, want 7", mode);
        end
        for (int k = 1; k <= fill_n; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (led_out !== fill_exp[((k - 1) / 4) % 5]) begin
                errors++;
                $display("FAIL fill_k%0d: got led=%b, want %b", k, led_out, fill_exp[((k - 1) / 4) % 5]);
            end
        end
    endtask

    task automatic test_pause();
        int k;
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        repeat (9) cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (mode !== 3'd2 || led_out !== 4'b0100) begin
            errors++;
            $display("FAIL walk_step2: got mode=%0d led=%b, want 2/0100", mode, led_out);
        end
        cycle(1'b0, 1'b0, 1'b1);
        k = m_presc;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (led_out !== 4'b0100 || running !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold_%0d: got led=%b run=%b, want 0100/0", i, led_out, running);
            end
        end
        cycle(1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= TICK_DIV - k; j++) begin
            logic [3:0] want;
            cycle(1'b0, 1'b0, 1'b0);
            want = (j == TICK_DIV - k) ? 4'b1000 : 4'b0100;
            checks++;
            if (led_out !== want) begin
                errors++;
                $display("FAIL resume_j%0d_k%0d: got led=%b, want %b", j, k, led_out, want);
            end
        end
    endtask

    task automatic test_arbitration();
        cycle(1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (running !== 1'b0 || mode !== 3'd3) begin
            errors++;
            $display("FAIL arb_pause_wins: got run=%b mode=%0d, want 0/3", running, mode);
        end
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (running !== 1'b1 || mode !== 3'd4) begin
            errors++;
            $display("FAIL arb_next_wins: got run=%b mode=%0d, want 1/4", running, mode);
        end
    endtask

    task automatic test_reset_mid_run();
        repeat (2) cycle(1'b0, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mode, led_out, running} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got mode=%0d led=%b run=%b, want 0/0000/0", mode, led_out, running);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (running !== 1'b1 || mode !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_run: got run=%b mode=%0d, want 1/0", running, mode);
        end
    endtask

    task automatic test_auto();
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            int want;
            cycle(1'b0, 1'b0, 1'b0);
`ifdef LED_SCHED_AUTO_EN
            want = 1 + k / (TICK_DIV * AUTO_TICKS);
`else
            want = 1;
`endif
            checks++;
            if (mode !== 3'(want)) begin
                errors++;
                $display("FAIL auto_k%0d: got mode=%0d, want %0d", k, mode, want);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_next_blink();
        test_fill();
        test_pause();
        test_arbitration();
        test_reset_mid_run();
        test_auto();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/led_pattern_sched.md
# led_pattern_sched

Key-driven LED display controller that sequences the 4-LED output stage. It takes one-cycle debounced key pulses (next, prev, pause) and arbitrates between them. It holds the current display mode (0–7) and steps a per-mode LED pattern on a prescaled tick. It sits between the key debouncers and the board LEDs, replacing direct key-count-to-LED mapping with a run/pause sequencer.

## Interface
- TICK_DIV, 50_000_000: clk cycles per pattern step (≥2).
- AUTO_TICKS, 16: ticks without key activity before auto mode advance (only with LED_SCHED_AUTO_EN).
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- key_next  in  1  debounced one-cycle pulse: next mode.
- key_prev  in  1  debounced one-cycle pulse: previous mode.
- key_pause  in  1  debounced one-cycle pulse: toggle run/pause.
- mode  out  3  current mode, registered.
- led_out  out  4  LED drive, active-high, registered.
- running  out  1  high in RUN state.

## Operation
- Reset values: state IDLE, mode 0, step 0, prescaler 0, led_out 4'b0000, running 0.
- FSM states:
  - IDLE: outputs dark. Any key pulse goes to RUN with mode 0, step 0. The pulse is consumed and does not change mode.
  - RUN: prescaler counts 0..TICK_DIV-1, with a tick on the terminal count. Each tick advances step modulo the mode length.
  - PAUSE: prescaler and step frozen; led_out holds its last value.
- Transitions:
  - key_pause: RUN→PAUSE, PAUSE→RUN.
  - key_next / key_prev in RUN or PAUSE: mode ±1, wrapping 7→0 and 0→7. State is unchanged.
  - A mode change clears step and prescaler.
- Same-cycle arbitration: key_pause > key_next > key_prev. Lower-priority pulses in that cycle are discarded, not queued.
- Patterns (step index from 0):
  - 0: 0000.
  - 1: 1111.
  - 2: 0001,0010,0100,1000.
  - 3: 1000,0100,0010,0001.
  - 4: step[3:0] binary, 16 steps.
  - 5: 0000,1111.
  - 6: 0001,0010,0100,1000,0100,0010.
  - 7: 0000,0001,0011,0111,1111.
- Step width is 4 bits. It wraps to 0 after last index = length−1.

## Timing
- Key pulse sampled at edge N: mode/step/state update at N, led_out reflects the new pattern at edge N+1 (one-cycle pattern register latency).
- Tick at prescaler terminal at edge N: step updates at N, led_out at N+1. Step period is exactly TICK_DIV cycles in uninterrupted RUN.
- Pause at edge N: prescaler value kept. Resume continues from the kept value, with no restart.
- Asserting rst at any time, including mid-step or in PAUSE, forces the reset values immediately, without waiting for a clock edge. The first edge after deassertion is a normal IDLE cycle.

## Configuration
- LED_SCHED_AUTO_EN defined: an idle counter counts RUN ticks since the last key pulse. On reaching AUTO_TICKS it advances mode +1 (wrap 7→0), clears step/prescaler and restarts counting. Any key pulse clears the counter. The counter is frozen in PAUSE.
- Undefined: mode changes only via keys. The idle counter is not present.

## Structure
- Package led_sched_pkg:
  - state enum {IDLE, RUN, PAUSE}.
  - mode constants MODE_OFF..MODE_FILL.
  - per-mode pattern length constant array.
  - LED/mode/step width constants.
- One sub-module, led_pattern_rom: combinational (mode, step) → 4-bit pattern. The parent registers its output.

## Test plan
All runs use TICK_DIV=4, AUTO_TICKS=3.
- Reset mid-RUN, mode 2: rst high → led_out 0000, mode 0, running 0 with no clock edge. After release, the next key_pause → running 1, mode 0.
- IDLE, key_next → RUN. Five key_next pulses → mode 5. led_out alternates 0000/1111 every 4 cycles, each change one cycle after the tick.
- Mode 0, key_prev → mode 7. Over 20 cycles led_out follows 0000,0001,0011,0111,1111 and wraps to 0000.
- Mode 2 at step 2 (0100), key_pause → led_out holds 0100 for 50 cycles. Second key_pause → 1000 exactly 4−k cycles later, where k is the prescaler value at pause.
- key_pause, key_next and key_prev in the same cycle in RUN mode 3 → state PAUSE, mode stays 3. key_next and key_prev in the same cycle → mode 4.
- With LED_SCHED_AUTO_EN: RUN mode 1 with no keys → mode 2 after 12 cycles, mode 3 after 24. Without the macro, mode stays 1 indefinitely.
